// File: rtl/fwd_pkg.sv
// Shared types for the hazard/forwarding controller and the EX-stage operand forwarder.
// Select encodings here are the contract between the two blocks.
package fwd_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_NONE        = 2'b00,
    FWD_FROM_EX_MEM = 2'b01,
    FWD_FROM_MEM_WB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_STALL,
    ST_MUL_BUSY
  } stall_state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
    logic              is_mul;
  } dest_rec_t;

  // d1 is one instruction ahead of the consumer, d2 two ahead; the nearer producer wins.
  function automatic fwd_sel_e pick_sel(input logic used, input logic [REG_AW-1:0] rs,
                                        input dest_rec_t d1, input dest_rec_t d2);
    fwd_sel_e sel;
    sel = FWD_NONE;
    if (used && rs != '0) begin
      if (d1.valid && d1.we && d1.rd == rs)
        sel = FWD_FROM_EX_MEM;
      else if (d2.valid && d2.we && d2.rd == rs)
        sel = FWD_FROM_MEM_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_dest_rec.sv
// Shadow destination record for one pipeline register.
// Hold keeps the current record; bubble loads an invalid one.
module hazard_dest_rec
  import fwd_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  logic      bubble,
  input  dest_rec_t d,
  output dest_rec_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (hold)
      q <= q;
    else if (bubble)
      q <= '0;
    else
      q <= d;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: registers EX operand selects with the instruction and
// stalls the front end on load-use and while the multi-cycle multiplier owns EX.
module hazard_fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_AW,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_we,
  input  logic                  id_mem_re,
  input  logic                  id_mul,
  input  logic                  ex_flush,
  output logic [1:0]            op_a_sel,
  output logic [1:0]            op_b_sel,
  output logic                  stall_if,
  output logic                  hold_idex,
  output logic                  bubble_idex,
  output logic                  bubble_exmem,
  output logic                  ex_first
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  stall_state_e state, state_nxt;
  logic [3:0]   mul_cnt, mul_cnt_nxt;
  dest_rec_t    id_rec, idex_rec, exmem_rec;
  fwd_sel_e     sel_a_nxt, sel_b_nxt, sel_a_q, sel_b_q;
  logic         load_use, advance, mul_enter;

  always_comb begin
    id_rec         = '0;
    id_rec.valid   = id_valid;
    id_rec.rd      = id_rd;
    id_rec.we      = id_reg_we;
    id_rec.is_load = id_mem_re;
    id_rec.is_mul  = id_mul;
  end

  // Only the two nearest producers need tracking; older results come through regfile write-through.
  hazard_dest_rec u_idex_rec (
    .clk(clk), .rst_n(rst_n), .hold(hold_idex), .bubble(bubble_idex), .d(id_rec), .q(idex_rec)
  );

  hazard_dest_rec u_exmem_rec (
    .clk(clk), .rst_n(rst_n), .hold(1'b0), .bubble(bubble_exmem), .d(idex_rec), .q(exmem_rec)
  );

  assign load_use = id_valid && idex_rec.valid && idex_rec.is_load && (idex_rec.rd != '0) &&
                    ((id_use_rs1 && id_rs1 == idex_rec.rd) || (id_use_rs2 && id_rs2 == idex_rec.rd));

  assign sel_a_nxt = pick_sel(id_valid && id_use_rs1, id_rs1, idex_rec, exmem_rec);
  assign sel_b_nxt = pick_sel(id_valid && id_use_rs2, id_rs2, idex_rec, exmem_rec);

  assign advance   = !hold_idex && !bubble_idex;
  assign mul_enter = advance && id_valid && id_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  // The multiply spends MUL_LAT-1 held cycles in EX plus one final cycle back in RUN.
  always_comb begin
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    case (state)
      ST_MUL_BUSY: begin
        mul_cnt_nxt = mul_cnt - 4'd1;
        if (mul_cnt == 4'd1)
          state_nxt = ST_RUN;
      end
      default: begin
        if (mul_enter) begin
          state_nxt   = ST_MUL_BUSY;
          mul_cnt_nxt = MUL_LOAD;
        end else if (state == ST_RUN && load_use && !ex_flush)
          state_nxt = ST_LOAD_STALL;
        else
          state_nxt = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall_if     = 1'b0;
    hold_idex    = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    case (state)
      ST_MUL_BUSY: begin
        stall_if     = 1'b1;
        hold_idex    = 1'b1;
        bubble_exmem = 1'b1;
      end
      ST_RUN: begin
        if (ex_flush)
          bubble_idex = 1'b1;
        else if (load_use) begin
          stall_if    = 1'b1;
          bubble_idex = 1'b1;
        end
      end
      default: bubble_idex = ex_flush;
    endcase
  end

  // Selects travel with the instruction; EX latches multiplier operands on ex_first only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_q  <= FWD_NONE;
      sel_b_q  <= FWD_NONE;
      ex_first <= 1'b0;
    end else if (hold_idex) begin
      ex_first <= 1'b0;
    end else if (bubble_idex) begin
      sel_a_q  <= FWD_NONE;
      sel_b_q  <= FWD_NONE;
      ex_first <= 1'b0;
    end else begin
      sel_a_q  <= sel_a_nxt;
      sel_b_q  <= sel_b_nxt;
      ex_first <= id_valid;
    end
  end

  assign op_a_sel = sel_a_q;
  assign op_b_sel = sel_b_q;

  // A branch cannot resolve in EX while the multiplier occupies it.
  a_no_flush_in_mul: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(state == ST_MUL_BUSY && ex_flush));

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: each cycle's expected outputs are queued when
// the ID instruction is driven and compared on the following falling edge.
module tb_hazard_fwd_ctrl;
  import fwd_pkg::*;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mul;
  } ins_t;

  localparam logic [1:0] N = FWD_NONE;
  localparam logic [1:0] E = FWD_FROM_EX_MEM;
  localparam logic [1:0] M = FWD_FROM_MEM_WB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_we, id_mem_re, id_mul, ex_flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] op_a_sel, op_b_sel;
  logic       stall_if, hold_idex, bubble_idex, bubble_exmem, ex_first;
  logic [8:0] obs;

  int         total = 0;
  int         bad = 0;
  string      tag_q[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mul(id_mul), .ex_flush(ex_flush),
    .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .stall_if(stall_if), .hold_idex(hold_idex),
    .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem), .ex_first(ex_first)
  );

  assign obs = {op_a_sel, op_b_sel, stall_if, hold_idex, bubble_idex, bubble_exmem, ex_first};

  function automatic logic [8:0] ev(input logic [1:0] a, input logic [1:0] b, input logic st,
                                    input logic ho, input logic bi, input logic be, input logic ef);
    return {a, b, st, ho, bi, be, ef};
  endfunction

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.rs1 = rs1; i.u1 = 1'b1; i.rs2 = rs2; i.u2 = 1'b1; i.rd = rd; i.we = 1'b1;
    return i;
  endfunction

  function automatic ins_t ldi(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t i;
    i = alu(rd, rs1, 5'd0);
    i.u2 = 1'b0;
    i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t mulo(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t i;
    i = alu(rd, rs1, rs2);
    i.mul = 1'b1;
    return i;
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got {a,b,stall,hold,bub_idex,bub_exmem,first}=%b want=%b", tag, got, want);
    end
  endtask

  task automatic driveIns(input ins_t i, input logic flush);
    id_valid   = i.v;
    id_rs1     = i.rs1;
    id_use_rs1 = i.u1;
    id_rs2     = i.rs2;
    id_use_rs2 = i.u2;
    id_rd      = i.rd;
    id_reg_we  = i.we;
    id_mem_re  = i.ld;
    id_mul     = i.mul;
    ex_flush   = flush;
  endtask

  task automatic applyStimulus(input string tag, input ins_t i, input logic flush, input logic [8:0] e);
    @(posedge clk);
    #1;
    driveIns(i, flush);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0)
      checkOutput(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ins_t t;
    rst_n = 1'b0;
    driveIns(nop(), 1'b0);
    #3;
    checkOutput("reset", obs, 9'd0);
    #20;
    rst_n = 1'b1;

    applyStimulus("idle",       nop(),          1'b0, ev(N, N, 0, 0, 0, 0, 0));
    // distance-1 forward
    applyStimulus("d1_prod",    alu(3, 1, 2),   1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("d1_cons",    alu(4, 3, 0),   1'b0, ev(N, N, 0, 0, 0, 0, 1));
    applyStimulus("d1_sel",     nop(),          1'b0, ev(E, N, 0, 0, 0, 0, 1));
    // distance-2 forward on rs2, then both distances on the same register
    applyStimulus("d2_prod",    alu(3, 1, 2),   1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("d2_gap",     nop(),          1'b0, ev(N, N, 0, 0, 0, 0, 1));
    applyStimulus("d2_cons",    alu(6, 1, 3),   1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("prio_p1",    alu(3, 1, 2),   1'b0, ev(N, M, 0, 0, 0, 0, 1));
    applyStimulus("prio_p2",    alu(3, 1, 2),   1'b0, ev(N, N, 0, 0, 0, 0, 1));
    applyStimulus("prio_cons",  alu(8, 3, 3),   1'b0, ev(N, N, 0, 0, 0, 0, 1));
    applyStimulus("prio_sel",   nop(),          1'b0, ev(E, E, 0, 0, 0, 0, 1));
    // load-use stall, then load to r0 must not stall
    applyStimulus("lu_load",    ldi(5, 1),      1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("lu_stall",   alu(9, 5, 2),   1'b0, ev(N, N, 1, 0, 1, 0, 1));
    applyStimulus("lu_release", alu(9, 5, 2),   1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("lu_sel",     nop(),          1'b0, ev(M, N, 0, 0, 0, 0, 1));
    applyStimulus("r0_load",    ldi(0, 1),      1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("r0_cons",    alu(10, 0, 2),  1'b0, ev(N, N, 0, 0, 0, 0, 1));
    applyStimulus("r0_sel",     nop(),          1'b0, ev(N, N, 0, 0, 0, 0, 1));
    // multiply occupies EX for 4 cycles, 3 of them stalled
    applyStimulus("mul_issue",  mulo(7, 1, 2),  1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("mul_busy1",  alu(11, 1, 7), 1'b0, ev(N, N, 1, 1, 0, 1, 1));
    applyStimulus("mul_busy2",  alu(11, 1, 7), 1'b0, ev(N, N, 1, 1, 0, 1, 0));
    applyStimulus("mul_busy3",  alu(11, 1, 7), 1'b0, ev(N, N, 1, 1, 0, 1, 0));
    applyStimulus("mul_last",   alu(11, 1, 7), 1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("mul_sel",    nop(),          1'b0, ev(N, E, 0, 0, 0, 0, 1));
    // flush overrides the load-use stall
    applyStimulus("fl_load",    ldi(5, 1),      1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("fl_flush",   alu(12, 5, 2),  1'b1, ev(N, N, 0, 0, 1, 0, 1));
    applyStimulus("fl_after",   alu(13, 5, 2),  1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("fl_sel",     nop(),          1'b0, ev(M, N, 0, 0, 0, 0, 1));
    // unused source never stalls or forwards; store data forwards on rs2
    applyStimulus("un_load",    ldi(6, 1),      1'b0, ev(N, N, 0, 0, 0, 0, 0));
    t = alu(14, 6, 2);
    t.u1 = 1'b0;
    applyStimulus("un_src",     t,              1'b0, ev(N, N, 0, 0, 0, 0, 1));
    t = alu(0, 1, 6);
    t.we = 1'b0;
    applyStimulus("st_data",    t,              1'b0, ev(N, N, 0, 0, 0, 0, 1));
    applyStimulus("st_sel",     nop(),          1'b0, ev(N, M, 0, 0, 0, 0, 1));
    // asynchronous reset while the multiplier is busy
    applyStimulus("rst_mul",    mulo(7, 1, 2),  1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("rst_busy",   alu(11, 1, 7), 1'b0, ev(N, N, 1, 1, 0, 1, 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    driveIns(nop(), 1'b0);
    #1;
    checkOutput("async_rst", obs, 9'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus("post_rst",     alu(11, 1, 7), 1'b0, ev(N, N, 0, 0, 0, 0, 0));
    applyStimulus("post_rst_sel", nop(),          1'b0, ev(N, N, 0, 0, 0, 0, 1));

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(negedge clk);
    #1;
    checkOutput("drain", 9'(exp_q.size()), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
